// File: rtl/ahb_slave_interface.sv
// AHB-side front end of the AHB-to-APB bridge: transfer qualification, address decode,
// pipeline stages and read-data return. Define AHB_ERR_RESP_EN to build the ERROR-response FSM.
module ahb_slave_interface #(
    parameter logic [31:0] SLV0_BASE     = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE     = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE     = 32'h8800_0000,
    parameter int unsigned SLV_SIZE_LOG2 = 26
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        valid,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic [2:0]  tempselx,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic        Herr_stall
);

    logic hit0, hit1, hit2, addr_hit;

    always_comb begin
        hit0     = (Haddr[31:SLV_SIZE_LOG2] == SLV0_BASE[31:SLV_SIZE_LOG2]);
        hit1     = (Haddr[31:SLV_SIZE_LOG2] == SLV1_BASE[31:SLV_SIZE_LOG2]);
        hit2     = (Haddr[31:SLV_SIZE_LOG2] == SLV2_BASE[31:SLV_SIZE_LOG2]);
        addr_hit = hit0 | hit1 | hit2;
        // Priority chain keeps the select one-hot even with overlapping bases
        if (hit0)      tempselx = 3'b001;
        else if (hit1) tempselx = 3'b010;
        else if (hit2) tempselx = 3'b100;
        else           tempselx = 3'b000;
        valid  = Hreadyin & Htrans[1] & addr_hit;
        Hrdata = Prdata;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Haddr1    <= '0;
            Haddr2    <= '0;
            Hwdata1   <= '0;
            Hwdata2   <= '0;
            Hwritereg <= 1'b0;
        end else if (Hreadyin) begin
            Haddr1    <= Haddr;
            Haddr2    <= Haddr1;
            Hwdata1   <= Hwdata;
            Hwdata2   <= Hwdata1;
            Hwritereg <= Hwrite;
        end
    end

`ifdef AHB_ERR_RESP_EN
    typedef enum logic [1:0] {E_IDLE, E_FIRST, E_SECOND} err_state_t;

    err_state_t state_q, state_d;
    logic       unmapped;

    always_comb begin
        unmapped = Hreadyin & Htrans[1] & ~addr_hit;
        state_d  = state_q;
        case (state_q)
            E_IDLE:   if (unmapped) state_d = E_FIRST;
            E_FIRST:  state_d = E_SECOND;
            E_SECOND: state_d = unmapped ? E_FIRST : E_IDLE;
            default:  state_d = E_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight from flops
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q    <= E_IDLE;
            Hresp      <= 2'b00;
            Herr_stall <= 1'b0;
        end else begin
            state_q    <= state_d;
            Hresp      <= (state_d == E_IDLE) ? 2'b00 : 2'b01;
            Herr_stall <= (state_d == E_FIRST);
        end
    end
`else
    assign Hresp      = 2'b00;
    assign Herr_stall = 1'b0;
`endif

endmodule
